request_responder: RTL and testbench

//  Far end of the row-request AXI-Stream link: accepts single-beat row requests (row in TDATA[7:0],

---
 rtl/request_responder.sv | 192 +++++++++++++++++++
 tb/tb_request_responder.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/request_responder.sv
// request_responder: far end of the row-request AXI-Stream link.
// Accepts single-beat row requests, queues them in a small circular FIFO and
// answers each with a BEATS_PER_ROW-beat response packet (TLAST on the final beat).
// Optional feature macro: ROW_RANGE_CHECK_EN (drop requests with row >= MAX_ROWS).
module request_responder #(
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int BEATS_PER_ROW  = 4,
  parameter int MAX_ROWS       = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] AXIS_RX_TDATA,
  input  logic         AXIS_RX_TVALID,
  output logic         AXIS_RX_TREADY,
  output logic [255:0] AXIS_TX_TDATA,
  output logic         AXIS_TX_TVALID,
  output logic         AXIS_TX_TLAST,
  input  logic         AXIS_TX_TREADY,
  output logic [31:0]  REQ_COUNT,
  output logic [31:0]  RESP_COUNT,
  output logic [15:0]  ERR_COUNT
);

  localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(REQ_FIFO_DEPTH);
  localparam logic [7:0]       LAST_BEAT = 8'(BEATS_PER_ROW - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t r_state;
  state_t w_state_next;

  // Queue storage: each entry is {frame[15:0], row[7:0]}
  logic [23:0]      r_mem [REQ_FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_rx_tready;

  // Packet currently being transmitted
  logic [7:0]  r_row;
  logic [15:0] r_frame;
  logic [7:0]  r_beat;
  logic [31:0] r_seq;
  logic [31:0] r_req_count;
  logic [31:0] r_resp_count;

  logic        w_rx_hs;
  logic        w_row_ok;
  logic        w_push;
  logic        w_empty;
  logic        w_tx_hs;
  logic        w_last_hs;
  logic        w_pop;
  logic [23:0] w_head;
  logic [23:0] w_unused_rx;

  // Only row and frame are carried; the rest of the request word is ignored
  assign w_unused_rx = ^{AXIS_RX_TDATA[255:32], AXIS_RX_TDATA[15:8]} ? 24'd1 : 24'd0;

`ifdef ROW_RANGE_CHECK_EN
  logic [15:0] r_err_count;
  logic        w_drop;

  assign w_row_ok = (32'(AXIS_RX_TDATA[7:0]) < 32'(MAX_ROWS));
  assign w_drop   = w_rx_hs & ~w_row_ok;

  // Out-of-range requests are handshaken but only counted; counter saturates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= '0;
    end else if (w_drop && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign ERR_COUNT = r_err_count;
`else
  logic [31:0] w_unused_max_rows;

  // Range limit only matters when range checking is built in
  assign w_unused_max_rows = 32'(MAX_ROWS);
  assign w_row_ok  = 1'b1;
  assign ERR_COUNT = '0;
`endif

  assign w_rx_hs      = AXIS_RX_TVALID & r_rx_tready;
  assign w_push       = w_rx_hs & w_row_ok;
  assign w_empty      = (r_count == '0);
  assign w_tx_hs      = (r_state == S_SEND) & AXIS_TX_TREADY;
  assign w_last_hs    = w_tx_hs & (r_beat == LAST_BEAT);
  // Pop from IDLE, or on the final beat handshake for zero-bubble back-to-back packets
  assign w_pop        = ~w_empty & ((r_state == S_IDLE) | w_last_hs);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Queue storage write port (no reset needed, occupancy tracks validity)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {AXIS_RX_TDATA[31:16], AXIS_RX_TDATA[7:0]};
    end
  end

  // Queue pointers, occupancy and registered ready (not full next cycle)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rx_tready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_next;
      r_rx_tready <= (w_count_next != FULL_CNT);
    end
  end

  // TX FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // TX FSM next state: leave SEND only when the last beat goes and nothing is queued
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (!w_empty) w_state_next = S_SEND;
      S_SEND: if (w_last_hs && w_empty) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // TX FSM outputs: valid for the whole SEND state, last on the final beat index
  always_comb begin
    AXIS_TX_TVALID = 1'b0;
    AXIS_TX_TLAST  = 1'b0;
    if (r_state == S_SEND) begin
      AXIS_TX_TVALID = 1'b1;
      AXIS_TX_TLAST  = (r_beat == LAST_BEAT);
    end
  end

  // Packet datapath: latch a new request on pop, advance beat index on handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row   <= '0;
      r_frame <= '0;
      r_beat  <= '0;
      r_seq   <= '0;
    end else if (w_pop) begin
      r_row   <= w_head[7:0];
      r_frame <= w_head[23:8];
      r_beat  <= '0;
      // Back-to-back start sees the response count after the finishing packet
      r_seq   <= r_resp_count + (w_last_hs ? 32'd1 : 32'd0);
    end else if (w_tx_hs && !w_last_hs) begin
      r_beat  <= r_beat + 8'd1;
    end
  end

  // Request / response counters, wrapping at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_count  <= '0;
      r_resp_count <= '0;
    end else begin
      if (w_push)    r_req_count  <= r_req_count + 32'd1;
      if (w_last_hs) r_resp_count <= r_resp_count + 32'd1;
    end
  end

  assign AXIS_RX_TREADY = r_rx_tready;
  assign REQ_COUNT      = r_req_count;
  assign RESP_COUNT     = r_resp_count;

  // Beat format: row, beat index, frame, sequence, then six {frame,row,beat} words
  assign AXIS_TX_TDATA[7:0]   = r_row;
  assign AXIS_TX_TDATA[15:8]  = r_beat;
  assign AXIS_TX_TDATA[31:16] = r_frame;
  assign AXIS_TX_TDATA[63:32] = r_seq;
  for (genvar gi = 0; gi < 6; gi++) begin : g_rep_word
    assign AXIS_TX_TDATA[64 + 32*gi +: 32] = {r_frame, r_row, r_beat};
  end

endmodule

// File: tb/tb_request_responder.sv
// tb_request_responder: randomized self-checking bench for request_responder.
// Reference model: a queue of expected {frame,row} packets plus a packet counter;
// every TX handshake is compared against the beat derived from the queue head.
`timescale 1ns/1ps
module tb_request_responder;
  localparam int DEPTH = 4;
  localparam int BEATS = 4;
  localparam int MAXR  = 128;

`ifdef ROW_RANGE_CHECK_EN
  localparam int E_ERR = 1;
  localparam int E_REQ = 2;
`else
  localparam int E_ERR = 0;
  localparam int E_REQ = 3;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] rx_tdata;
  logic         rx_tvalid;
  logic         rx_tready;
  logic [255:0] tx_tdata;
  logic         tx_tvalid;
  logic         tx_tlast;
  logic         tx_tready;
  logic [31:0]  req_count;
  logic [31:0]  resp_count;
  logic [15:0]  err_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [23:0]  exp_q[$];
  int           exp_beat;
  int           exp_seq;
  int           mdl_req;
  int           mdl_err;
  int           cyc;
  int           tx_hs_n;
  int           first_tx_cyc;
  int           last_tx_cyc;
  bit           stalled_prev;
  logic [255:0] hold_data;
  logic         hold_last;

  always #5 clk = ~clk;

  request_responder #(
    .REQ_FIFO_DEPTH(DEPTH),
    .BEATS_PER_ROW (BEATS),
    .MAX_ROWS      (MAXR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .AXIS_RX_TDATA (rx_tdata),
    .AXIS_RX_TVALID(rx_tvalid),
    .AXIS_RX_TREADY(rx_tready),
    .AXIS_TX_TDATA (tx_tdata),
    .AXIS_TX_TVALID(tx_tvalid),
    .AXIS_TX_TLAST (tx_tlast),
    .AXIS_TX_TREADY(tx_tready),
    .REQ_COUNT     (req_count),
    .RESP_COUNT    (resp_count),
    .ERR_COUNT     (err_count)
  );

  function automatic bit row_ok(input logic [7:0] row);
    int lim;
    lim = 256;
`ifdef ROW_RANGE_CHECK_EN
    lim = MAXR;
`endif
    return (int'(row) < lim);
  endfunction

  function automatic logic [255:0] make_req(input int row, input int frame);
    logic [255:0] d;
    d = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    d[7:0]   = row[7:0];
    d[31:16] = frame[15:0];
    return d;
  endfunction

  function automatic logic [255:0] beat_word(input logic [7:0] row, input logic [15:0] frame,
                                             input int beat, input int seq);
    logic [255:0] w;
    w        = '0;
    w[7:0]   = row;
    w[15:8]  = beat[7:0];
    w[31:16] = frame;
    w[63:32] = seq[31:0];
    for (int i = 0; i < 6; i++) w[64 + 32*i +: 32] = {frame, row, beat[7:0]};
    return w;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    exp_beat     = 0;
    exp_seq      = 0;
    mdl_req      = 0;
    mdl_err      = 0;
    tx_hs_n      = 0;
    first_tx_cyc = 0;
    last_tx_cyc  = 0;
    stalled_prev = 1'b0;
  endtask

  task automatic release_reset();
    rx_tvalid = 1'b0;
    rx_tdata  = '0;
    tx_tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_model();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    release_reset();
  endtask

  // One clock: drive inputs at negedge, score the handshakes about to happen at the next posedge
  task automatic run_cycle(input bit v, input logic [255:0] d, input bit rdy, output bit acc);
    logic [23:0]  pkt;
    logic [255:0] exp_w;
    logic         exp_last;
    @(negedge clk);
    rx_tvalid = v;
    rx_tdata  = d;
    tx_tready = rdy;
    #1;
    cyc++;
    if (stalled_prev) begin
      total++;
      if (tx_tvalid !== 1'b1 || tx_tdata !== hold_data || tx_tlast !== hold_last) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got valid=%b last=%b data=%h want valid=1 last=%b data=%h",
                 cyc, tx_tvalid, tx_tlast, tx_tdata, hold_last, hold_data);
      end
    end
    if (tx_tvalid === 1'b1 && rdy) begin
      tx_hs_n++;
      if (tx_hs_n == 1) first_tx_cyc = cyc;
      last_tx_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat cyc=%0d got data=%h want no beat", cyc, tx_tdata);
      end else begin
        pkt      = exp_q[0];
        exp_w    = beat_word(pkt[7:0], pkt[23:8], exp_beat, exp_seq);
        exp_last = (exp_beat == BEATS - 1);
        if (tx_tdata !== exp_w || tx_tlast !== exp_last) begin
          bad++;
          $display("FAIL tx_beat cyc=%0d got last=%b data=%h want last=%b data=%h",
                   cyc, tx_tlast, tx_tdata, exp_last, exp_w);
        end
        exp_beat++;
        if (exp_beat == BEATS) begin
          $display("packet seq=%0d row=%0d frame=%0d complete", exp_seq, pkt[7:0], pkt[23:8]);
          void'(exp_q.pop_front());
          exp_beat = 0;
          exp_seq++;
        end
      end
    end
    stalled_prev = (tx_tvalid === 1'b1) && !rdy;
    hold_data    = tx_tdata;
    hold_last    = tx_tlast;
    acc = v && (rx_tready === 1'b1);
    if (acc) begin
      if (row_ok(d[7:0])) begin
        exp_q.push_back({d[31:16], d[7:0]});
        mdl_req++;
      end else begin
        mdl_err++;
      end
    end
  endtask

  task automatic drain(input bit rnd);
    bit acc;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      run_cycle(1'b0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      if (exp_q.size() == 0 && tx_tvalid !== 1'b1) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
    end
  endtask

  // Offer one request until accepted (bounded)
  task automatic send_req(input int row, input int frame, input bit rdy);
    bit acc;
    logic [255:0] d;
    acc = 1'b0;
    d = make_req(row, frame);
    for (int i = 0; i < 100 && !acc; i++) run_cycle(1'b1, d, rdy, acc);
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL req_accept row=%0d got accepted=0 want 1", row);
    end
  endtask

  task automatic test_reset();
    bit acc;
    reset     = 1'b0;
    rx_tvalid = 1'b0;
    rx_tdata  = '0;
    tx_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total += 5;
    if (tx_tvalid !== 1'b0 || tx_tlast !== 1'b0) begin
      bad++; $display("FAIL reset_tx got valid=%b last=%b want 0 0", tx_tvalid, tx_tlast);
    end
    if (tx_tdata !== '0) begin
      bad++; $display("FAIL reset_tdata got %h want 0", tx_tdata);
    end
    if (rx_tready !== 1'b0) begin
      bad++; $display("FAIL reset_rx_tready got %b want 0", rx_tready);
    end
    if (req_count !== 32'd0 || resp_count !== 32'd0) begin
      bad++; $display("FAIL reset_counts got req=%0d resp=%0d want 0 0", req_count, resp_count);
    end
    if (err_count !== 16'd0) begin
      bad++; $display("FAIL reset_err got %0d want 0", err_count);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    run_cycle(1'b0, '0, 1'b1, acc);
    total++;
    if (rx_tready !== 1'b1) begin
      bad++; $display("FAIL ready_after_reset got %b want 1", rx_tready);
    end
  endtask

  task automatic test_single();
    bit acc;
    int lat;
    do_reset();
    repeat (2) run_cycle(1'b0, '0, 1'b1, acc);
    total++;
    if (tx_tvalid !== 1'b0) begin
      bad++; $display("FAIL idle_valid got %b want 0", tx_tvalid);
    end
    send_req(5, 12, 1'b1);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      run_cycle(1'b0, '0, 1'b1, acc);
      if (tx_tvalid === 1'b1) lat = i;
    end
    total++;
    if (lat != 2) begin
      bad++; $display("FAIL first_beat_latency got %0d want 2", lat);
    end
    drain(1'b0);
    total += 2;
    if (tx_hs_n != BEATS) begin
      bad++; $display("FAIL single_beats got %0d want %0d", tx_hs_n, BEATS);
    end
    if (req_count !== 32'd1 || resp_count !== 32'd1) begin
      bad++; $display("FAIL single_counts got req=%0d resp=%0d want 1 1", req_count, resp_count);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int sent;
    do_reset();
    sent = 0;
    for (int i = 0; i < 200 && sent < 8; i++) begin
      run_cycle(1'b1, make_req(sent, 12), 1'b1, acc);
      if (acc) sent++;
    end
    drain(1'b0);
    total += 3;
    if (tx_hs_n != 8 * BEATS) begin
      bad++; $display("FAIL b2b_beats got %0d want %0d", tx_hs_n, 8 * BEATS);
    end
    if (last_tx_cyc - first_tx_cyc + 1 != 8 * BEATS) begin
      bad++; $display("FAIL b2b_gaps got span=%0d want %0d", last_tx_cyc - first_tx_cyc + 1, 8 * BEATS);
    end
    if (resp_count !== 32'd8 || req_count !== 32'd8) begin
      bad++; $display("FAIL b2b_counts got req=%0d resp=%0d want 8 8", req_count, resp_count);
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    int sent;
    do_reset();
    sent = 0;
    for (int i = 0; i < 20; i++) begin
      run_cycle(sent < 8, make_req(sent + 40, 3), 1'b0, acc);
      if (acc) sent++;
    end
    total += 2;
    if (sent != DEPTH + 1) begin
      bad++; $display("FAIL bp_accepted got %0d want %0d", sent, DEPTH + 1);
    end
    if (rx_tready !== 1'b0 || tx_tvalid !== 1'b1) begin
      bad++; $display("FAIL bp_flags got rx_ready=%b tx_valid=%b want 0 1", rx_tready, tx_tvalid);
    end
    for (int i = 0; i < 200 && sent < 8; i++) begin
      run_cycle(1'b1, make_req(sent + 40, 3), 1'b1, acc);
      if (acc) sent++;
    end
    drain(1'b0);
    total++;
    if (resp_count !== 32'd8 || req_count !== 32'd8) begin
      bad++; $display("FAIL bp_counts got req=%0d resp=%0d want 8 8", req_count, resp_count);
    end
  endtask

  task automatic test_random_stall();
    bit acc;
    int sent;
    do_reset();
    sent = 0;
    for (int i = 0; i < 600 && sent < 30; i++) begin
      run_cycle(1'($urandom_range(0, 1)),
                make_req(int'($urandom_range(0, 255)), int'($urandom_range(0, 65535))),
                1'($urandom_range(0, 1)), acc);
      if (acc) sent++;
    end
    drain(1'b1);
    total += 3;
    if (req_count !== 32'(mdl_req)) begin
      bad++; $display("FAIL rand_req got %0d want %0d", req_count, mdl_req);
    end
    if (resp_count !== 32'(exp_seq)) begin
      bad++; $display("FAIL rand_resp got %0d want %0d", resp_count, exp_seq);
    end
    if (err_count !== 16'(mdl_err)) begin
      bad++; $display("FAIL rand_err got %0d want %0d", err_count, mdl_err);
    end
  endtask

  task automatic test_range();
    do_reset();
    send_req(3, 7, 1'b1);
    send_req(200, 7, 1'b1);
    send_req(4, 7, 1'b1);
    drain(1'b0);
    total += 3;
    if (err_count !== 16'(E_ERR)) begin
      bad++; $display("FAIL range_err got %0d want %0d", err_count, E_ERR);
    end
    if (req_count !== 32'(E_REQ)) begin
      bad++; $display("FAIL range_req got %0d want %0d", req_count, E_REQ);
    end
    if (resp_count !== 32'(E_REQ)) begin
      bad++; $display("FAIL range_resp got %0d want %0d", resp_count, E_REQ);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    int seen;
    do_reset();
    send_req(20, 1, 1'b1);
    send_req(21, 1, 1'b1);
    for (int i = 0; i < 20 && !(exp_beat == 2 && exp_seq == 0); i++) run_cycle(1'b0, '0, 1'b1, acc);
    @(posedge clk);
    #2;
    total++;
    if (tx_tvalid !== 1'b1 || tx_tdata[15:8] !== 8'd2) begin
      bad++; $display("FAIL mid_setup got valid=%b beat=%0d want 1 2", tx_tvalid, tx_tdata[15:8]);
    end
    reset = 1'b0;
    #1;
    total += 3;
    if (tx_tvalid !== 1'b0 || tx_tlast !== 1'b0) begin
      bad++; $display("FAIL mid_async got valid=%b last=%b want 0 0", tx_tvalid, tx_tlast);
    end
    if (req_count !== 32'd0 || resp_count !== 32'd0) begin
      bad++; $display("FAIL mid_counts got req=%0d resp=%0d want 0 0", req_count, resp_count);
    end
    if (rx_tready !== 1'b0) begin
      bad++; $display("FAIL mid_rx_ready got %b want 0", rx_tready);
    end
    release_reset();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b0, '0, 1'b1, acc);
      if (tx_tvalid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL mid_queue_empty got valid_cycles=%0d want 0", seen);
    end
    send_req(9, 5, 1'b1);
    drain(1'b0);
    total++;
    if (resp_count !== 32'd1 || tx_hs_n != BEATS) begin
      bad++; $display("FAIL mid_after got resp=%0d beats=%0d want 1 %0d", resp_count, tx_hs_n, BEATS);
    end
  endtask

  initial begin
    cyc = 0;
    clear_model();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_range();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
